linear_visualizer: RTL and testbench
====================================

// Module: linear_visualizer
// PURPOSE
// - Turns per-note amplitude and position bins into LED colour and LED-count bins for the LED string driver.
// - Per bin, colour is a hue taken from the note position and scaled by brightness from the amplitude.
// - LED count is the bin's share of total above-floor amplitude times LEDS.
// - Sits between the note-finder output and LEDDriver2. Its rgb, LEDCounts and data_v feed the driver's rgb, LEDCounts and start.
// PARAMETERS
// W                   6      integer bits of fixed-point inputs
// D                   10     fraction bits (all fixed-point values are W.D)
// LEDS                50     LEDs in string
// BIN_QTY             12     number of note bins
// steadyBright        0      1: every active bin gets brightness LEDLimit
// LEDFloor            102    amplitude floor (~0.0996)
// LEDLimit            1023   brightness ceiling (~1.0)
// SaturationAmplifier 1638   brightness gain (~1.6)
// yellowToRedSlope    21824  hue ramp slope, segment Y->R (21.3125)
// redToBlueSlope      43648  hue ramp slope, segment R->B (42.625)
// blueToYellowSlope   65472  hue ramp slope, segment B->Y (63.9375)
// PORTS
// clk            in   1                       clock, all logic on posedge
// rst            in   1                       synchronous, active-high reset
// start          in   1                       request; a rising edge is accepted
// noteAmplitudes in   BIN_QTY x (W+D)         unsigned W.D amplitude per bin
// notePositions  in   BIN_QTY x (W+D)         unsigned W.D note position per bin
// rgb            out  BIN_QTY x 24            {R[23:16],G[15:8],B[7:0]} per bin
// LEDCounts      out  BIN_QTY x $clog2(LEDS)  LEDs assigned per bin
// data_v         out  1                       level: rgb/LEDCounts valid and stable
// BEHAVIOUR
// - Single clock domain.
// - Reset: FSM->IDLE; rgb, LEDCounts, data_v and internal accumulators = 0. A reset mid-computation aborts it.
// - FSM states:
//   - IDLE: data_v=0. Waits for start=1 with start_q=0, where start_q is start registered from the previous cycle.
//   - LATCH: 1 cycle. Captures both input arrays. Clears total.
//   - SUM: BIN_QTY cycles, one bin per cycle. Per bin:
//     - a' = amp>LEDFloor ? amp-LEDFloor : 0; total += a' (W+D+$clog2(BIN_QTY) bits, no overflow).
//     - bright = steadyBright ? (a'!=0 ? LEDLimit : 0) : min(LEDLimit, (a'*SaturationAmplifier)>>D).
//     - p = position, minus 24.0 if p>=24.0, once.
//     - Hue segment and channels, ramp r = min(255, (x*slope)>>(2D)) where x = p minus segment start:
//       - Y->R [0,12):  R=255,   G=255-r, B=0.
//       - R->B [12,18): R=255-r, G=0,     B=r.
//       - B->Y [18,24): R=r,     G=r,     B=255-r.
//     - Each channel out = (c*bright)>>D.
//     - a'==0 forces rgb=0 for that bin.
//   - DIV: per bin, LEDCounts[i] = floor(a'*LEDS/total).
//     - Restoring divider, QW=$clog2(LEDS+1) quotient bits, QW+1 cycles per bin.
//     - total==0: all counts 0 and all rgb 0.
//   - VALID: data_v=1; outputs held. Exits to LATCH on the next rising edge of start.
// - Latency: start edge to data_v = 2 + BIN_QTY + BIN_QTY*(QW+1) cycles; 98 at defaults.
// - data_v drops the cycle LATCH is entered and stays 0 until the new result is ready.
// - rgb and LEDCounts are updated only when VALID is entered (no partial results visible).
// - start held continuously high gives exactly one computation.
// - Sum of LEDCounts <= LEDS. The driver fills the remainder.
// - All arithmetic unsigned. Products are computed at full width before shift or clamp.
// CONFIGURATION
// - LV_REMAINDER_FILL_EN defined: after DIV, the leftover LEDS - sum(LEDCounts) is added to the bin with the largest a' (lowest index on tie). The sum then equals LEDS whenever total != 0.
// - Adds 1 cycle of latency.
// - LV_REMAINDER_FILL_EN undefined: no fill; counts are the floors as above.
// TESTING (defaults unless noted)
// - rst 10 cycles -> rgb=0, LEDCounts=0, data_v=0; data_v stays 0 while start=0.
// - All amps=102, start 0->1 -> data_v=1 after 98 cycles; all LEDCounts=0, all rgb=0.
// - Bin0 amp=1126 (a'=1024), pos=0 -> LEDCounts[0]=50, rgb[0]=24'hFEFE00 (bright clamped to 1023); other bins 0.
// - Bins0/1 a'=512, pos=12.0/18.0 -> counts 25/25, rgb 24'hCB0000 / 24'h0000CB (bright 819).
// - Bins0..2 a'=300 -> counts 16/16/16; with LV_REMAINDER_FILL_EN: 18/16/16.
// - start held 1 -> one result only; start 1->0->1 -> data_v low, new result after 98 cycles.
// - rst asserted mid-SUM -> all outputs 0 next cycle.
// - steadyBright=1 with a'=10 -> bright=1023.

Source files
------------

// File: rtl/linear_visualizer.sv
// linear_visualizer: per-bin amplitude/position -> LED colour and LED share; optional LV_REMAINDER_FILL_EN.
// Latency: start rising edge to data_v = 2 + BIN_QTY + BIN_QTY*(QW+1) cycles, +1 with LV_REMAINDER_FILL_EN.
// Backpressure: none; start edges are ignored while busy, results held in VALID until the next start edge.
module linear_visualizer #(
    parameter int W                   = 6,
    parameter int D                   = 10,
    parameter int LEDS                = 50,
    parameter int BIN_QTY             = 12,
    parameter int steadyBright        = 0,
    parameter int LEDFloor            = 102,
    parameter int LEDLimit            = 1023,
    parameter int SaturationAmplifier = 1638,
    parameter int yellowToRedSlope    = 21824,
    parameter int redToBlueSlope      = 43648,
    parameter int blueToYellowSlope   = 65472
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [BIN_QTY-1:0][W+D-1:0]          noteAmplitudes,
    input  logic [BIN_QTY-1:0][W+D-1:0]          notePositions,
    output logic [BIN_QTY-1:0][23:0]             rgb,
    output logic [BIN_QTY-1:0][$clog2(LEDS)-1:0] LEDCounts,
    output logic                                 data_v
);
    localparam int DW = W + D;
    localparam int TW = DW + $clog2(BIN_QTY);
    localparam int CW = $clog2(LEDS);
    localparam int QW = $clog2(LEDS + 1);
    localparam int RW = TW + QW;
    localparam int BW = (BIN_QTY > 1) ? $clog2(BIN_QTY) : 1;
    localparam int SW = $clog2(QW + 1);
    localparam int PW = 2 * DW + 2;

    localparam logic [DW-1:0] FLOOR  = DW'(LEDFloor);
    localparam logic [DW-1:0] LIMIT  = DW'(LEDLimit);
    localparam logic [DW-1:0] WRAP   = DW'(24 << D);
    localparam logic [DW-1:0] SEG_RB = DW'(12 << D);
    localparam logic [DW-1:0] SEG_BY = DW'(18 << D);

    typedef enum logic [2:0] {IDLE, LATCH, SUM, DIV, FILL, VALID} state_t;

    state_t                        state;
    logic                          start_q;
    logic [BIN_QTY-1:0][DW-1:0]    amp_l;
    logic [BIN_QTY-1:0][DW-1:0]    pos_l;
    logic [BIN_QTY-1:0][DW-1:0]    abin;
    logic [BIN_QTY-1:0][23:0]      rgb_w;
    logic [BIN_QTY-1:0][CW-1:0]    cnt_w;
    logic [BIN_QTY-1:0][CW-1:0]    cnt_next;
    logic [TW-1:0]                 total;
    logic [BW-1:0]                 bin;
    logic [SW-1:0]                 step;
    logic [RW-1:0]                 rem;
    logic [QW-1:0]                 quo;

    // Per-bin colour/brightness datapath, evaluated on the bin selected during SUM
    logic [DW-1:0]   amp_c, a_c, bright, p_c, x_c;
    logic [PW-1:0]   sat_prod, sat_sh, slope_c, ramp_prod, ramp_sh;
    logic [7:0]      r_c, c_r, c_g, c_b;
    logic [DW+7:0]   pr_r, pr_g, pr_b;
    logic [23:0]     rgb_c;

    always_comb begin
        amp_c    = amp_l[bin];
        a_c      = (amp_c > FLOOR) ? amp_c - FLOOR : '0;
        sat_prod = PW'(a_c) * PW'(SaturationAmplifier);
        sat_sh   = sat_prod >> D;
        if (steadyBright != 0)
            bright = (a_c != '0) ? LIMIT : '0;
        else
            bright = (sat_sh > PW'(LEDLimit)) ? LIMIT : DW'(sat_sh);

        p_c = pos_l[bin];
        if (p_c >= WRAP)
            p_c = p_c - WRAP;

        if (p_c < SEG_RB) begin
            x_c     = p_c;
            slope_c = PW'(yellowToRedSlope);
        end else if (p_c < SEG_BY) begin
            x_c     = p_c - SEG_RB;
            slope_c = PW'(redToBlueSlope);
        end else begin
            x_c     = p_c - SEG_BY;
            slope_c = PW'(blueToYellowSlope);
        end
        ramp_prod = PW'(x_c) * slope_c;
        ramp_sh   = ramp_prod >> (2 * D);
        r_c       = (ramp_sh > PW'(255)) ? 8'hFF : 8'(ramp_sh);

        if (p_c < SEG_RB) begin
            c_r = 8'hFF;        c_g = 8'hFF - r_c;  c_b = 8'h00;
        end else if (p_c < SEG_BY) begin
            c_r = 8'hFF - r_c;  c_g = 8'h00;        c_b = r_c;
        end else begin
            c_r = r_c;          c_g = r_c;          c_b = 8'hFF - r_c;
        end

        pr_r  = (DW+8)'(c_r) * (DW+8)'(bright);
        pr_g  = (DW+8)'(c_g) * (DW+8)'(bright);
        pr_b  = (DW+8)'(c_b) * (DW+8)'(bright);
        rgb_c = (a_c == '0) ? 24'h0 : {8'(pr_r >> D), 8'(pr_g >> D), 8'(pr_b >> D)};
    end

    // Restoring divider: one quotient bit per cycle, MSB first
    logic [SW-1:0] div_sh;
    logic [RW-1:0] trial;
    logic          ge;
    logic [QW-1:0] q_next;

    always_comb begin
        div_sh = SW'(QW) - step;
        trial  = RW'(total) << div_sh;
        ge     = (rem >= trial);
        q_next = quo | (QW'(ge) << div_sh);
    end

`ifdef LV_REMAINDER_FILL_EN
    localparam int SUMW = $clog2(LEDS * BIN_QTY + 1);
    logic [BW-1:0]   max_idx;
    logic [DW-1:0]   max_val;
    logic [SUMW-1:0] sum_c, fill_c;

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < BIN_QTY; i++)
            sum_c = sum_c + SUMW'(cnt_w[i]);
        fill_c = SUMW'(LEDS) - sum_c;
    end
`endif

    always_comb begin
        cnt_next = cnt_w;
        if (state == DIV && step == SW'(QW))
            cnt_next[bin] = (total == '0) ? '0 : CW'(q_next);
`ifdef LV_REMAINDER_FILL_EN
        if (state == FILL && total != '0)
            cnt_next[max_idx] = cnt_w[max_idx] + CW'(fill_c);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            start_q   <= 1'b0;
            amp_l     <= '0;
            pos_l     <= '0;
            abin      <= '0;
            rgb_w     <= '0;
            cnt_w     <= '0;
            total     <= '0;
            bin       <= '0;
            step      <= '0;
            rem       <= '0;
            quo       <= '0;
            rgb       <= '0;
            LEDCounts <= '0;
            data_v    <= 1'b0;
`ifdef LV_REMAINDER_FILL_EN
            max_idx   <= '0;
            max_val   <= '0;
`endif
        end else begin
            start_q <= start;
            cnt_w   <= cnt_next;
            case (state)
                IDLE, VALID: begin
                    if (start && !start_q) begin
                        state  <= LATCH;
                        data_v <= 1'b0;
                    end
                end
                LATCH: begin
                    amp_l <= noteAmplitudes;
                    pos_l <= notePositions;
                    total <= '0;
                    bin   <= '0;
                    state <= SUM;
                end
                SUM: begin
                    abin[bin]  <= a_c;
                    rgb_w[bin] <= rgb_c;
                    total      <= total + TW'(a_c);
`ifdef LV_REMAINDER_FILL_EN
                    if (bin == '0 || a_c > max_val) begin
                        max_val <= a_c;
                        max_idx <= bin;
                    end
`endif
                    if (bin == BW'(BIN_QTY - 1)) begin
                        bin   <= '0;
                        step  <= '0;
                        state <= DIV;
                    end else begin
                        bin <= bin + 1'b1;
                    end
                end
                DIV: begin
                    if (step == '0) begin
                        rem  <= RW'(abin[bin]) * RW'(LEDS);
                        quo  <= '0;
                        step <= step + 1'b1;
                    end else begin
                        if (ge)
                            rem <= rem - trial;
                        quo <= q_next;
                        if (step == SW'(QW)) begin
                            step <= '0;
                            if (bin == BW'(BIN_QTY - 1)) begin
                                bin <= '0;
`ifdef LV_REMAINDER_FILL_EN
                                state <= FILL;
`else
                                state     <= VALID;
                                data_v    <= 1'b1;
                                rgb       <= rgb_w;
                                LEDCounts <= cnt_next;
`endif
                            end else begin
                                bin <= bin + 1'b1;
                            end
                        end else begin
                            step <= step + 1'b1;
                        end
                    end
                end
`ifdef LV_REMAINDER_FILL_EN
                FILL: begin
                    state     <= VALID;
                    data_v    <= 1'b1;
                    rgb       <= rgb_w;
                    LEDCounts <= cnt_next;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_linear_visualizer.sv
// Self-checking bench for linear_visualizer: directed cases plus randomized bins against a behavioural model.
module tb_linear_visualizer;
    localparam int BQ = 12;
`ifdef LV_REMAINDER_FILL_EN
    localparam int LAT = 99;
`else
    localparam int LAT = 98;
`endif

    typedef logic [BQ-1:0][15:0] vec_t;
    typedef logic [BQ-1:0][23:0] rgb_t;
    typedef logic [BQ-1:0][5:0]  cnt_t;

    logic clk, rst, start;
    vec_t amps, pos;
    rgb_t rgb_o, rgb_s;
    cnt_t cnt_o, cnt_s;
    logic data_v, dv_s;

    int errors = 0;
    int checks = 0;

    linear_visualizer dut (
        .clk(clk), .rst(rst), .start(start),
        .noteAmplitudes(amps), .notePositions(pos),
        .rgb(rgb_o), .LEDCounts(cnt_o), .data_v(data_v)
    );

    linear_visualizer #(.steadyBright(1)) dut_s (
        .clk(clk), .rst(rst), .start(start),
        .noteAmplitudes(amps), .notePositions(pos),
        .rgb(rgb_s), .LEDCounts(cnt_s), .data_v(dv_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint ramp(input longint x, input longint s);
        longint v;
        v = (x * s) / 1048576;
        return (v > 255) ? 255 : v;
    endfunction

    // Reference: colour from hue segment times brightness, count = share of above-floor total
    task automatic model(input vec_t am, input vec_t ps, input bit steady,
                         output rgb_t er, output cnt_t ec);
        longint a [BQ];
        longint tot, br, p, rr, cr, cg, cb;
        tot = 0;
        for (int i = 0; i < BQ; i++) begin
            a[i] = (am[i] > 16'd102) ? longint'(am[i]) - 102 : 0;
            tot += a[i];
        end
        for (int i = 0; i < BQ; i++) begin
            if (steady) br = (a[i] != 0) ? 1023 : 0;
            else begin
                br = a[i] * 1638 / 1024;
                if (br > 1023) br = 1023;
            end
            p = longint'(ps[i]);
            if (p >= 24 * 1024) p -= 24 * 1024;
            if (p < 12 * 1024) begin
                rr = ramp(p, 21824); cr = 255; cg = 255 - rr; cb = 0;
            end else if (p < 18 * 1024) begin
                rr = ramp(p - 12 * 1024, 43648); cr = 255 - rr; cg = 0; cb = rr;
            end else begin
                rr = ramp(p - 18 * 1024, 65472); cr = rr; cg = rr; cb = 255 - rr;
            end
            er[i] = (a[i] == 0) ? 24'h0 : {8'(cr * br / 1024), 8'(cg * br / 1024), 8'(cb * br / 1024)};
            ec[i] = (tot == 0) ? 6'd0 : 6'(a[i] * 50 / tot);
        end
`ifdef LV_REMAINDER_FILL_EN
        if (tot != 0) begin
            int m;
            longint sum;
            m = 0; sum = 0;
            for (int i = 0; i < BQ; i++) begin
                sum += longint'(ec[i]);
                if (a[i] > a[m]) m = i;
            end
            ec[m] = 6'(longint'(ec[m]) + 50 - sum);
        end
`endif
    endtask

    task automatic run_compute(output int lat);
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        lat = -1;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk); #1;
            if (data_v) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; amps = '0; pos = '0;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (rgb_o !== '0) begin errors++; $display("FAIL reset_rgb got %h want 0", rgb_o); end
        checks++; if (cnt_o !== '0) begin errors++; $display("FAIL reset_cnt got %h want 0", cnt_o); end
        checks++; if (data_v !== 1'b0) begin errors++; $display("FAIL reset_dv got %b want 0", data_v); end
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (data_v !== 1'b0) begin errors++; $display("FAIL idle_dv got %b want 0", data_v); end
    endtask

    task automatic test_floor;
        int lat;
        for (int i = 0; i < BQ; i++) begin
            amps[i] = 16'd102;
            pos[i]  = 16'($urandom_range(0, 65535));
        end
        run_compute(lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL floor_latency got %0d want %0d", lat, LAT); end
        checks++; if (cnt_o !== '0) begin errors++; $display("FAIL floor_cnt got %h want 0", cnt_o); end
        checks++; if (rgb_o !== '0) begin errors++; $display("FAIL floor_rgb got %h want 0", rgb_o); end
    endtask

    task automatic test_single_bin;
        int lat;
        amps = '0; pos = '0;
        amps[0] = 16'd1126;
        run_compute(lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL single_latency got %0d want %0d", lat, LAT); end
        checks++; if (cnt_o[0] !== 6'd50) begin errors++; $display("FAIL single_cnt0 got %0d want 50", cnt_o[0]); end
        checks++; if (rgb_o[0] !== 24'hFEFE00) begin errors++; $display("FAIL single_rgb0 got %h want fefe00", rgb_o[0]); end
        for (int i = 1; i < BQ; i++) begin
            checks++;
            if (cnt_o[i] !== 6'd0 || rgb_o[i] !== 24'h0) begin
                errors++; $display("FAIL single_other bin %0d got %0d/%h want 0/0", i, cnt_o[i], rgb_o[i]);
            end
        end
    endtask

    task automatic test_hue_pair;
        int lat;
        amps = '0; pos = '0;
        amps[0] = 16'd614; pos[0] = 16'd12288;
        amps[1] = 16'd614; pos[1] = 16'd18432;
        run_compute(lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL pair_latency got %0d want %0d", lat, LAT); end
        checks++; if (cnt_o[0] !== 6'd25 || cnt_o[1] !== 6'd25) begin
            errors++; $display("FAIL pair_cnt got %0d/%0d want 25/25", cnt_o[0], cnt_o[1]); end
        checks++; if (rgb_o[0] !== 24'hCB0000) begin errors++; $display("FAIL pair_rgb0 got %h want cb0000", rgb_o[0]); end
        checks++; if (rgb_o[1] !== 24'h0000CB) begin errors++; $display("FAIL pair_rgb1 got %h want 0000cb", rgb_o[1]); end
    endtask

    task automatic test_three_bins;
        int lat;
        cnt_t want;
        amps = '0; pos = '0;
        for (int i = 0; i < 3; i++) amps[i] = 16'd402;
        want = '0;
`ifdef LV_REMAINDER_FILL_EN
        want[0] = 6'd18;
`else
        want[0] = 6'd16;
`endif
        want[1] = 6'd16; want[2] = 6'd16;
        run_compute(lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL three_latency got %0d want %0d", lat, LAT); end
        checks++; if (cnt_o !== want) begin errors++; $display("FAIL three_cnt got %h want %h", cnt_o, want); end
    endtask

    task automatic test_random;
        int lat;
        rgb_t er;
        cnt_t ec;
        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < BQ; i++) begin
                amps[i] = ($urandom_range(0, 9) < 3) ? 16'($urandom_range(0, 102))
                                                     : 16'($urandom_range(103, 4000));
                pos[i]  = 16'($urandom_range(0, 65535));
            end
            if (it == 7) amps = '0;
            model(amps, pos, 1'b0, er, ec);
            run_compute(lat);
            checks++; if (lat != LAT) begin errors++; $display("FAIL rand_latency it %0d got %0d want %0d", it, lat, LAT); end
            for (int i = 0; i < BQ; i++) begin
                checks++;
                if (rgb_o[i] !== er[i]) begin errors++; $display("FAIL rand_rgb it %0d bin %0d got %h want %h", it, i, rgb_o[i], er[i]); end
                checks++;
                if (cnt_o[i] !== ec[i]) begin errors++; $display("FAIL rand_cnt it %0d bin %0d got %0d want %0d", it, i, cnt_o[i], ec[i]); end
            end
        end
    endtask

    task automatic test_start_held;
        int lat, bad;
        cnt_t held;
        rgb_t er;
        cnt_t ec;
        for (int i = 0; i < BQ; i++) begin
            amps[i] = 16'($urandom_range(103, 3000));
            pos[i]  = 16'($urandom_range(0, 65535));
        end
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        lat = -1;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk); #1;
            if (data_v) begin lat = n; break; end
        end
        checks++; if (lat != LAT) begin errors++; $display("FAIL held_latency got %0d want %0d", lat, LAT); end
        held = cnt_o;
        amps = '0;
        bad = 0;
        repeat (150) begin
            @(posedge clk); #1;
            if (data_v !== 1'b1 || cnt_o !== held) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL held_single_result got %0d bad cycles want 0", bad); end
        start = 1'b0;
        @(posedge clk); #1;
        checks++; if (data_v !== 1'b1) begin errors++; $display("FAIL held_low_dv got %b want 1", data_v); end
        for (int i = 0; i < BQ; i++) amps[i] = 16'($urandom_range(0, 2000));
        model(amps, pos, 1'b0, er, ec);
        start = 1'b1;
        @(posedge clk); #1;
        checks++; if (data_v !== 1'b0) begin errors++; $display("FAIL restart_dv_drop got %b want 0", data_v); end
        lat = -1;
        for (int n = 2; n <= 300; n++) begin
            @(posedge clk); #1;
            if (data_v) begin lat = n; break; end
        end
        start = 1'b0;
        checks++; if (lat != LAT) begin errors++; $display("FAIL restart_latency got %0d want %0d", lat, LAT); end
        checks++; if (cnt_o !== ec) begin errors++; $display("FAIL restart_cnt got %h want %h", cnt_o, ec); end
        checks++; if (rgb_o !== er) begin errors++; $display("FAIL restart_rgb got %h want %h", rgb_o, er); end
    endtask

    task automatic test_mid_reset;
        int bad;
        for (int i = 0; i < BQ; i++) amps[i] = 16'($urandom_range(200, 2000));
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (data_v !== 1'b0) begin errors++; $display("FAIL busy_dv got %b want 0", data_v); end
        rst = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (rgb_o !== '0) begin errors++; $display("FAIL midrst_rgb got %h want 0", rgb_o); end
        checks++; if (cnt_o !== '0) begin errors++; $display("FAIL midrst_cnt got %h want 0", cnt_o); end
        checks++; if (data_v !== 1'b0) begin errors++; $display("FAIL midrst_dv got %b want 0", data_v); end
        rst = 1'b0;
        bad = 0;
        repeat (120) begin
            @(posedge clk); #1;
            if (data_v !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL midrst_aborted got %0d valid cycles want 0", bad); end
    endtask

    task automatic test_steady;
        int lat;
        rgb_t er;
        cnt_t ec;
        amps = '0; pos = '0;
        amps[0] = 16'd112;
        amps[1] = 16'd150; pos[1] = 16'd12288;
        model(amps, pos, 1'b1, er, ec);
        run_compute(lat);
        checks++; if (lat != LAT || dv_s !== 1'b1) begin
            errors++; $display("FAIL steady_latency got %0d/%b want %0d/1", lat, dv_s, LAT); end
        checks++; if (rgb_s[0] !== 24'hFEFE00) begin errors++; $display("FAIL steady_rgb0 got %h want fefe00", rgb_s[0]); end
        checks++; if (rgb_s[1] !== 24'hFE0000) begin errors++; $display("FAIL steady_rgb1 got %h want fe0000", rgb_s[1]); end
        checks++; if (rgb_s !== er) begin errors++; $display("FAIL steady_rgb got %h want %h", rgb_s, er); end
        checks++; if (cnt_s !== ec) begin errors++; $display("FAIL steady_cnt got %h want %h", cnt_s, ec); end
        checks++; if (rgb_o[0] !== 24'h030300) begin errors++; $display("FAIL scaled_rgb0 got %h want 030300", rgb_o[0]); end
    endtask

    initial begin
        test_reset();
        test_floor();
        test_single_bin();
        test_hue_pair();
        test_three_bins();
        test_random();
        test_start_held();
        test_mid_reset();
        test_steady();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
